// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the five-stage pipeline.
// Merges per-stage stall requests into a stall vector, sequences exception/ERET
// flushes (deferring them while the data bus is busy) and keeps stall debug counters.
module pipeline_ctrl #(
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        exc_pending,
    output logic [31:0] stall_cycles,
    output logic        stall_timeout
);

    localparam logic [31:0] ExcEret = 32'h0000_000e;
    localparam int unsigned CntW    = $clog2(STALL_TIMEOUT + 1);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(STALL_TIMEOUT);

    typedef enum logic [0:0] {
        StRun,
        StExcWait
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     exc_code_q, exc_code_d;
    logic [31:0]     epc_q, epc_d;
    logic [31:0]     stall_cycles_q, stall_cycles_d;
    logic [CntW-1:0] consec_q, consec_d;
    logic            timeout_q, timeout_d;
    logic [5:0]      req_stall;
    logic            stalled;

    // ERET returns to EPC; every other nonzero code enters the exception vector.
    function automatic logic [31:0] redirect_pc(input logic [31:0] code,
                                                input logic [31:0] epc);
        return (code == ExcEret) ? epc : EXC_VECTOR;
    endfunction

    // Latest stage requesting a stall wins; it freezes itself and everything before it.
    always_comb begin
        req_stall = 6'b000000;
        if (stallreq_mem) begin
            req_stall = 6'b011111;
        end else if (stallreq_ex) begin
            req_stall = 6'b001111;
        end else if (stallreq_id) begin
            req_stall = 6'b000111;
        end else if (stallreq_if) begin
            req_stall = 6'b000011;
        end
    end

    // Exception sequencing: next state, latches and combinational stall/flush/new_pc.
    always_comb begin
        state_d    = state_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        flush      = 1'b0;
        new_pc     = 32'h0;
        stall      = req_stall;
        unique case (state_q)
            StRun: begin
                if (excepttype_i != 32'h0) begin
                    if (!stallreq_mem) begin
                        flush  = 1'b1;
                        new_pc = redirect_pc(excepttype_i, cp0_epc_i);
                    end else begin
                        // Data bus busy: hold the exception until the access completes.
                        exc_code_d = excepttype_i;
                        epc_d      = cp0_epc_i;
                        state_d    = StExcWait;
                    end
                end
            end
            StExcWait: begin
                if (!stallreq_mem) begin
                    flush   = 1'b1;
                    new_pc  = redirect_pc(exc_code_q, epc_q);
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
        if (flush) begin
            stall = 6'b000000;
        end
    end

    assign stalled = (stall != 6'b000000);

    // Debug counters: total stalled cycles and saturating consecutive-stall run length.
    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'h0, stalled};
        consec_d       = consec_q;
        timeout_d      = timeout_q;
        if (!stalled || flush) begin
            consec_d = '0;
        end else if (consec_q != TimeoutVal) begin
            consec_d = consec_q + 1'b1;
        end
        if (stalled && (consec_d == TimeoutVal)) begin
            timeout_d = 1'b1;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StRun;
            exc_code_q     <= 32'h0;
            epc_q          <= 32'h0;
            stall_cycles_q <= 32'h0;
            consec_q       <= '0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            exc_code_q     <= exc_code_d;
            epc_q          <= epc_d;
            stall_cycles_q <= stall_cycles_d;
            consec_q       <= consec_d;
            timeout_q      <= timeout_d;
        end
    end

    assign exc_pending   = (state_q == StExcWait);
    assign stall_cycles  = stall_cycles_q;
    assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_pipeline_ctrl;

    localparam logic [31:0] ExcVec = 32'h0000_0020;
    localparam int unsigned To     = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_if, r_id, r_ex, r_mem;
    logic [31:0] exc, epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        exc_pending;
    logic [31:0] stall_cycles;
    logic        stall_timeout;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state.
    bit          m_pend;
    logic [31:0] m_code, m_epc;
    logic [31:0] m_cycles;
    int unsigned m_run;
    bit          m_to;

    // Last observed combinational outputs.
    logic [5:0]  o_stall;
    logic        o_flush;
    logic [31:0] o_pc;

    pipeline_ctrl #(
        .EXC_VECTOR   (ExcVec),
        .STALL_TIMEOUT(To)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (r_if),
        .stallreq_id  (r_id),
        .stallreq_ex  (r_ex),
        .stallreq_mem (r_mem),
        .excepttype_i (exc),
        .cp0_epc_i    (epc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .exc_pending  (exc_pending),
        .stall_cycles (stall_cycles),
        .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Highest requesting stage k (if=0..mem=3) stalls stages 0..k+1.
    function automatic logic [5:0] req_mask(input logic i, input logic d, input logic e,
                                            input logic m);
        int k = -1;
        if (i) k = 0;
        if (d) k = 1;
        if (e) k = 2;
        if (m) k = 3;
        if (k < 0) return 6'd0;
        return 6'((1 << (k + 2)) - 1);
    endfunction

    function automatic logic [31:0] target(input logic [31:0] code, input logic [31:0] e);
        return (code == 32'he) ? e : ExcVec;
    endfunction

    // One clock cycle: entered 1 time unit after a rising edge with inputs already driven.
    task automatic cycle();
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        #3;
        e_flush = 1'b0;
        e_pc    = 32'h0;
        e_stall = req_mask(r_if, r_id, r_ex, r_mem);
        if (m_pend) begin
            if (!r_mem) begin
                e_flush = 1'b1;
                e_pc    = target(m_code, m_epc);
            end
        end else if (exc != 0 && !r_mem) begin
            e_flush = 1'b1;
            e_pc    = target(exc, epc);
        end
        if (e_flush) e_stall = 6'd0;
        o_stall = stall;
        o_flush = flush;
        o_pc    = new_pc;
        check("stall", {26'h0, stall}, {26'h0, e_stall});
        check("flush", {31'h0, flush}, {31'h0, e_flush});
        check("new_pc", new_pc, e_pc);
        check("exc_pending", {31'h0, exc_pending}, {31'h0, m_pend});
        check("stall_cycles", stall_cycles, m_cycles);
        check("stall_timeout", {31'h0, stall_timeout}, {31'h0, m_to});
        @(posedge clk);
        #1;
        if (rst) begin
            m_pend = 0; m_code = 0; m_epc = 0; m_cycles = 0; m_run = 0; m_to = 0;
        end else begin
            if (m_pend) begin
                if (!r_mem) m_pend = 0;
            end else if (exc != 0 && r_mem) begin
                m_pend = 1; m_code = exc; m_epc = epc;
            end
            if (e_stall != 0) begin
                m_cycles = m_cycles + 1;
                m_run = (m_run >= To) ? To : m_run + 1;
                if (m_run == To) m_to = 1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic idle_inputs();
        r_if = 0; r_id = 0; r_ex = 0; r_mem = 0; exc = 0; epc = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        m_pend = 0; m_code = 0; m_epc = 0; m_cycles = 0; m_run = 0; m_to = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Priority between requests.
        r_if = 1; r_ex = 1;
        cycle();
        check("prio_if_ex", {26'h0, o_stall}, 32'h0f);
        r_if = 0; r_ex = 0; r_mem = 1;
        cycle();
        check("prio_mem", {26'h0, o_stall}, 32'h1f);
        r_mem = 0;
        cycle();
        check("prio_none", {26'h0, o_stall}, 32'h0);
        check("cycles_after_prio", stall_cycles, 32'd2);

        // Immediate exception and ERET.
        exc = 32'h8;
        cycle();
        check("imm_flush", {31'h0, o_flush}, 32'h1);
        check("imm_pc", o_pc, 32'h20);
        exc = 32'he; epc = 32'hBFC0_0100;
        cycle();
        check("eret_pc", o_pc, 32'hBFC0_0100);
        idle_inputs();
        cycle();
        check("post_flush", {31'h0, o_flush}, 32'h0);

        // Deferred flush: latched overflow wins over later codes.
        exc = 32'hc; r_mem = 1; epc = 32'h1234_5678;
        cycle();
        check("defer1_flush", {31'h0, o_flush}, 32'h0);
        check("defer_pending", {31'h0, exc_pending}, 32'h1);
        exc = 32'h1;
        cycle();
        cycle();
        check("defer3_stall", {26'h0, o_stall}, 32'h1f);
        exc = 32'he; r_mem = 0;
        cycle();
        check("defer4_flush", {31'h0, o_flush}, 32'h1);
        check("defer4_pc", o_pc, 32'h20);
        check("defer4_stall", {26'h0, o_stall}, 32'h0);
        idle_inputs();
        cycle();

        // Reset in the middle of a deferral discards the exception.
        exc = 32'hd; r_mem = 1;
        cycle();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("rst_noflush", {31'h0, o_flush}, 32'h0);
        end
        check("rst_pending", {31'h0, exc_pending}, 32'h0);
        check("rst_cycles", stall_cycles, 32'h0);

        // Timeout: 7 stalls, gap, 8 stalls.
        r_id = 1;
        for (int i = 0; i < 7; i++) cycle();
        r_id = 0;
        cycle();
        check("to_first_run", {31'h0, stall_timeout}, 32'h0);
        r_id = 1;
        for (int i = 0; i < 7; i++) cycle();
        check("to_before", {31'h0, stall_timeout}, 32'h0);
        cycle();
        check("to_rise", {31'h0, stall_timeout}, 32'h1);
        r_id = 0;
        cycle();
        cycle();
        check("to_sticky", {31'h0, stall_timeout}, 32'h1);

        // Random traffic.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic [31:0] codes [6];
            codes[0] = 32'h1; codes[1] = 32'h8; codes[2] = 32'ha;
            codes[3] = 32'hc; codes[4] = 32'hd; codes[5] = 32'he;
            rst   = ($urandom_range(0, 99) == 0);
            r_if  = ($urandom_range(0, 3) == 0);
            r_id  = ($urandom_range(0, 3) == 0);
            r_ex  = ($urandom_range(0, 3) == 0);
            r_mem = ($urandom_range(0, 2) == 0);
            exc   = ($urandom_range(0, 5) == 0) ? codes[$urandom_range(0, 5)] : 32'h0;
            epc   = $urandom;
            cycle();
        end
        rst = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the five-stage MIPS pipeline. It merges per-stage stall requests into the 6-bit `stall` vector consumed by the PC register and every pipeline register (including EX/MEM). It sequences exception/ERET flushes, deferring them while the data bus is busy, and keeps debug counters for stall cycles and stall timeouts.

## Interface
**Parameters**
- `EXC_VECTOR`, default 32'h0000_0020: exception entry PC.
- `STALL_TIMEOUT`, default 1024: consecutive-stall cycle count that raises `stall_timeout`.

**Ports**
- `clk` input 1: clock.
- `rst` input 1: synchronous, active-high reset.
- `stallreq_if` input 1: instruction bus wait.
- `stallreq_id` input 1: load-use hazard.
- `stallreq_ex` input 1: multi-cycle EX op (madd/msub/div) in progress.
- `stallreq_mem` input 1: data bus wait.
- `excepttype_i` input 32: exception code from MEM stage; 0 means none.
- `cp0_epc_i` input 32: current EPC from CP0.
- `stall` output 6: stage stalls. Bit 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB.
- `flush` output 1: clear all pipeline registers this cycle.
- `new_pc` output 32: redirect target, valid when `flush`=1.
- `exc_pending` output 1: high in EXC_WAIT.
- `stall_cycles` output 32: count of cycles with `stall`≠0.
- `stall_timeout` output 1: sticky flag, cleared only by reset.

## Operation
- Stall encoding is combinational from the requests. The latest stage has priority:
  - mem → 6'b011111
  - else ex → 6'b001111
  - else id → 6'b000111
  - else if → 6'b000011
  - else 6'b000000
- FSM states: RUN, EXC_WAIT.
- **RUN**
  - If `excepttype_i`≠0 and `stallreq_mem`=0: this cycle `flush`=1, `stall`=0, `new_pc` computed from `excepttype_i`/`cp0_epc_i`. Stay in RUN.
  - If `excepttype_i`≠0 and `stallreq_mem`=1: `flush`=0 and `stall` is per the requests. Latch the code and EPC into `exc_code_q`/`epc_q`, then go to EXC_WAIT.
  - Otherwise: normal stall encoding, `flush`=0.
- **EXC_WAIT**
  - `stall` is per the requests; `exc_pending`=1.
  - When `stallreq_mem`=0: `flush`=1, `stall`=0, `new_pc` from the latched values. Return to RUN.
  - New `excepttype_i` values are ignored while in EXC_WAIT; the latched code wins.
- `new_pc` selection:
  - code 32'h0000_000e (ERET) → EPC.
  - any other nonzero code (0x1 interrupt, 0x8 syscall, 0xa RI, 0xc overflow, 0xd trap) → `EXC_VECTOR`.
  - `new_pc`=0 whenever `flush`=0.
- `flush` overrides all stall requests: `stall` is forced to 0 in any flush cycle.
- `stall_cycles` increments by 1 each cycle `stall`≠0. It wraps 32'hFFFF_FFFF → 0 with no flag.
- Consecutive-stall counter:
  - Counts cycles with `stall`≠0.
  - Clears on any cycle with `stall`=0 or `flush`=1.
  - Saturates at `STALL_TIMEOUT`.
  - Reaching `STALL_TIMEOUT` sets `stall_timeout`=1.

## Timing
- Reset values:
  - State RUN.
  - `flush`=0, `new_pc`=0, `stall`=0 (while requests are low), `exc_pending`=0.
  - `stall_cycles`=0, `stall_timeout`=0, consecutive counter 0, latches 0.
- Reset overrides everything, including mid-EXC_WAIT: the latched exception is discarded and no flush is issued.
- `stall`, `flush` and `new_pc` are combinational: a request in cycle N affects the pipeline registers at the edge ending cycle N.
- A deferred flush asserts in the first cycle in which `stallreq_mem`=0. The FSM is in RUN from the next cycle.
- The registered `exc_pending` rises one cycle after the deferring exception and falls at the edge ending the flush cycle.
- `stall_cycles` and the timeout counter update at the clock edge following the counted cycle. `stall_timeout` rises at the edge on which the count reaches `STALL_TIMEOUT`.
- Back-to-back exceptions are allowed: a flush in cycle N and a new `excepttype_i` in cycle N+1 produce a second flush in N+1.

## Test plan
- Priority: drive `stallreq_if`=1 and `stallreq_ex`=1 together → `stall`=6'b001111. Then `stallreq_mem` alone → 6'b011111. All low → 0, and `stall_cycles` equals the number of stalled cycles.
- Immediate exception: `excepttype_i`=32'h8 with no stall request → same cycle `flush`=1, `new_pc`=32'h20, `stall`=0. Next cycle `flush`=0.
- ERET: `excepttype_i`=32'he, `cp0_epc_i`=32'hBFC0_0100 → `flush`=1, `new_pc`=32'hBFC0_0100.
- Deferred flush: `excepttype_i`=32'hc with `stallreq_mem`=1 held 3 cycles, `excepttype_i` changed to 0x1 in cycle 2, then `stallreq_mem`=0. Required response:
  - `stall`=6'b011111 for the 3 cycles, no flush, `exc_pending`=1.
  - In the 4th cycle: `flush`=1, `new_pc`=32'h20 (latched 0xc wins), `stall`=0.
- Reset mid-EXC_WAIT: assert `rst` during the deferral, then release with all inputs 0 → no flush ever, `exc_pending`=0, counters 0.
- Timeout (`STALL_TIMEOUT`=8): hold `stallreq_id` 7 cycles, drop 1 cycle, hold 8 cycles → `stall_timeout` stays 0 through the first run. It rises at the 8th stalled edge of the second run and stays 1 after the requests drop.
